fpdiv: RTL and testbench

Sequential fixed-point divider, the inverse operation of the `fpmult` multiplier in the same arithmetic unit. It accepts sign-magnitude P.Q operands and produces the rounded quotient with a shift-subtract (restoring) datapath. Its start/valid/ready handshake, rounding-mode encoding and out-of-range vector match the multiplier's, so both can share one issue controller.

---
 rtl/fpdiv_pkg.sv | 23 ++
 rtl/fpdiv_divstep.sv | 25 ++
 rtl/fpdiv.sv | 164 ++++++++++++++++
 tb/tb_fpdiv.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the fpdiv sequential divider.
package fpdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    ROUND = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Rounding-mode encoding, shared with the multiplier's issue controller.
  localparam logic [1:0] RND_ZERO = 2'b00;
  localparam logic [1:0] RND_NEAR = 2'b01;
  localparam logic [1:0] RND_POS  = 2'b10;
  localparam logic [1:0] RND_NEG  = 2'b11;

  // Bit positions inside the out-of-range status vector.
  localparam int OOR_OVF = 0;
  localparam int OOR_UNF = 1;
  localparam int OOR_DBZ = 2;
  localparam int OOR_INX = 3;

endpackage

// File: rtl/fpdiv_divstep.sv
// One restoring-division step: shift the next numerator bit into the
// partial remainder and trial-subtract the divisor magnitude.
module divstep #(
  parameter int M = 15
) (
  input  logic [M-1:0] rem_i,
  input  logic         bit_i,
  input  logic [M-1:0] div_i,
  output logic [M-1:0] rem_o,
  output logic         q_o
);

  logic [M:0] part;
  logic [M:0] diff;

  // Trial subtraction; the remainder is restored when the divisor does not fit.
  always_comb begin
    part  = {rem_i, bit_i};
    diff  = part - {1'b0, div_i};
    q_o   = (part >= {1'b0, div_i});
    // Either branch is below the divisor, so M bits always hold it.
    rem_o = q_o ? diff[M-1:0] : part[M-1:0];
  end

endmodule

// File: rtl/fpdiv.sv
// Sequential sign-magnitude P.Q divider with restoring datapath, directed
// rounding and saturation. Optional build macro FPDIV_EARLY_DBZ_EN makes a
// divide-by-zero complete in the cycle after accept instead of running the
// full iteration sequence.
module fpdiv
  import fpdiv_pkg::*;
#(
  parameter int P = 8,
  parameter int Q = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [P+Q-1:0]   x_in,
  input  logic [P+Q-1:0]   y_in,
  input  logic [1:0]       round_in,
  input  logic             start_in,
  output logic [P+Q-1:0]   p_out,
  output logic [3:0]       oor_out,
  output logic             valid_out,
  output logic             ready_out
);

  localparam int W    = P + Q;
  localparam int M    = W - 1;
  localparam int ITER = W + Q;
  localparam int CW   = $clog2(ITER);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  // Numerator bits shift out of the top while quotient bits shift in at the
  // bottom; after ITER steps the register holds the guarded quotient.
  logic [ITER-1:0] nq_q;
  logic [M-1:0]    rem_q;
  logic [M-1:0]    ay_q;
  logic            sign_q;
  logic            xnz_q;
  logic [1:0]      rnd_q;
  logic [W-1:0]    p_q;
  logic [3:0]      oor_q;

  logic            accept;
  logic            early_dbz;
  logic [M-1:0]    step_rem;
  logic            step_q;

  assign accept = start_in && ready_out;

`ifdef FPDIV_EARLY_DBZ_EN
  assign early_dbz = (y_in[M-1:0] == '0);
`else
  assign early_dbz = 1'b0;
`endif

  divstep #(.M(M)) u_step (
    .rem_i (rem_q),
    .bit_i (nq_q[ITER-1]),
    .div_i (ay_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and infers a latch.
    state_d   = state_q;
    ready_out = (state_q == IDLE) || (state_q == DONE);
    valid_out = (state_q == DONE);
    case (state_q)
      IDLE:  if (accept) state_d = early_dbz ? DONE : BUSY;
      BUSY:  if (cnt_q == '0) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE:  state_d = accept ? (early_dbz ? DONE : BUSY) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rounding, saturation and status flags evaluated in the ROUND cycle.
  logic [ITER-1:0] q_ext;
  logic [ITER-1:0] q_inc;
  logic            guard;
  logic            sticky;
  logic            inc;
  logic            ovf;
  logic            unf;
  logic            dbz;
  logic [M-1:0]    mag;
  logic [W-1:0]    res_p;
  logic [3:0]      res_oor;

  always_comb begin
    q_ext  = {1'b0, nq_q[ITER-1:1]};
    guard  = nq_q[0];
    sticky = (rem_q != '0);
    case (rnd_q)
      RND_NEAR: inc = guard && (sticky || q_ext[0]);
      RND_POS:  inc = !sign_q && (guard || sticky);
      RND_NEG:  inc = sign_q && (guard || sticky);
      default:  inc = 1'b0;
    endcase
    q_inc = q_ext + {{(ITER-1){1'b0}}, inc};
    // q_inc >= q, so testing the incremented value covers both cases.
    ovf   = (q_inc[ITER-1:M] != '0);
    dbz   = (ay_q == '0);
    mag   = ovf ? {M{1'b1}} : q_inc[M-1:0];
    unf   = xnz_q && !ovf && (mag == '0);
    res_oor                 = '0;
    res_oor[OOR_OVF]        = ovf;
    res_oor[OOR_UNF]        = unf;
    res_oor[OOR_INX]        = guard || sticky || ovf || unf;
    if (dbz) begin
      mag     = {M{xnz_q}};
      res_oor = 4'b0100;
    end
    // A zero magnitude never carries a sign.
    res_p = {sign_q && (mag != '0), mag};
  end

  // Operand capture, iteration datapath and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      nq_q   <= '0;
      rem_q  <= '0;
      ay_q   <= '0;
      sign_q <= 1'b0;
      xnz_q  <= 1'b0;
      rnd_q  <= RND_ZERO;
      p_q    <= '0;
      oor_q  <= '0;
    end else if (accept) begin
      cnt_q  <= CW'(ITER - 1);
      nq_q   <= {x_in[M-1:0], {(Q+1){1'b0}}};
      rem_q  <= '0;
      ay_q   <= y_in[M-1:0];
      sign_q <= x_in[W-1] ^ y_in[W-1];
      xnz_q  <= (x_in[M-1:0] != '0);
      rnd_q  <= round_in;
      if (early_dbz) begin
        p_q   <= (x_in[M-1:0] != '0) ? {x_in[W-1] ^ y_in[W-1], {M{1'b1}}} : '0;
        oor_q <= 4'b0100;
      end
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - CW'(1);
      nq_q  <= {nq_q[ITER-2:0], step_q};
      rem_q <= step_rem;
    end else if (state_q == ROUND) begin
      p_q   <= res_p;
      oor_q <= res_oor;
    end
  end

  assign p_out   = p_q;
  assign oor_out = oor_q;

endmodule

// File: tb/tb_fpdiv.sv
// Directed self-checking bench for fpdiv at P=Q=8 (1.0 = 0x0100).
module tb_fpdiv;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [1:0]  round_in;
  logic        start_in;
  logic [15:0] p_out;
  logic [3:0]  oor_out;
  logic        valid_out;
  logic        ready_out;

  int n_checks = 0;
  int n_errors = 0;

  // Latency counts the start cycle as cycle 1.
  localparam int LAT = 26;
`ifdef FPDIV_EARLY_DBZ_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = LAT;
`endif

  fpdiv #(.P(8), .Q(8)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .round_in  (round_in),
    .start_in  (start_in),
    .p_out     (p_out),
    .oor_out   (oor_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called just after the accept edge; returns the cycle count at which
  // valid_out was first seen (100 means it never came).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_out && lat < 100) begin
      @(posedge clk_in); #1;
      lat++;
    end
  endtask

  task automatic accept_op(input logic [15:0] x, input logic [15:0] y, input logic [1:0] r);
    x_in = x; y_in = y; round_in = r; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic [1:0] r, input logic [15:0] ep, input logic [3:0] eo,
                        input int elat);
    int lat;
    accept_op(x, y, r);
    wait_valid(lat);
    check({tag, "/lat"}, lat, elat);
    check({tag, "/p"}, p_out, ep);
    check({tag, "/oor"}, oor_out, eo);
    @(posedge clk_in); #1;
    check({tag, "/pulse"}, valid_out, 1'b0);
  endtask

  task automatic count_valid(input int cycles, output int hits);
    hits = 0;
    repeat (cycles) begin
      @(posedge clk_in); #1;
      if (valid_out) hits++;
    end
  endtask

  initial begin
    int lat;
    int hits;
    rst_in = 1'b1; start_in = 1'b0; x_in = '0; y_in = '0; round_in = 2'b00;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst/p", p_out, 16'h0000);
    check("rst/oor", oor_out, 4'b0000);
    check("rst/valid", valid_out, 1'b0);
    check("rst/ready", ready_out, 1'b1);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    run_op("exact",   16'h0300, 16'h0200, 2'b00, 16'h0180, 4'b0000, LAT);
    run_op("third00", 16'h0100, 16'h0300, 2'b00, 16'h0055, 4'b1000, LAT);
    run_op("third01", 16'h0100, 16'h0300, 2'b01, 16'h0055, 4'b1000, LAT);
    run_op("third10", 16'h0100, 16'h0300, 2'b10, 16'h0056, 4'b1000, LAT);
    run_op("nthird11", 16'h8100, 16'h0300, 2'b11, 16'h8056, 4'b1000, LAT);
    run_op("nthird10", 16'h8100, 16'h0300, 2'b10, 16'h8055, 4'b1000, LAT);
    run_op("ovf_pos", 16'h7F00, 16'h0001, 2'b00, 16'h7FFF, 4'b1001, LAT);
    run_op("ovf_neg", 16'hFF00, 16'h0001, 2'b00, 16'hFFFF, 4'b1001, LAT);
    run_op("dbz_nz",  16'h8200, 16'h0000, 2'b00, 16'hFFFF, 4'b0100, DBZ_LAT);
    run_op("dbz_z",   16'h0000, 16'h8000, 2'b00, 16'h0000, 4'b0100, DBZ_LAT);
    run_op("unf00",   16'h8001, 16'h7F00, 2'b00, 16'h0000, 4'b1010, LAT);
    run_op("unf11",   16'h8001, 16'h7F00, 2'b11, 16'h8001, 4'b1000, LAT);

    // start_in pulses during BUSY must not disturb the running operation.
    accept_op(16'h0300, 16'h0200, 2'b00);
    lat = 1;
    repeat (3) begin @(posedge clk_in); #1; lat++; end
    check("busy/ready", ready_out, 1'b0);
    x_in = 16'h0100; y_in = 16'h0300; round_in = 2'b10; start_in = 1'b1;
    repeat (3) begin @(posedge clk_in); #1; lat++; end
    start_in = 1'b0;
    while (!valid_out && lat < 100) begin @(posedge clk_in); #1; lat++; end
    check("busy/lat", lat, LAT);
    check("busy/p", p_out, 16'h0180);
    check("busy/oor", oor_out, 4'b0000);
    count_valid(30, hits);
    check("busy/no_extra", hits, 0);

    // Back-to-back: accept in the DONE cycle; outputs hold across accept.
    accept_op(16'h0100, 16'h0300, 2'b00);
    wait_valid(lat);
    check("b2b1/lat", lat, LAT);
    check("b2b1/p", p_out, 16'h0055);
    accept_op(16'h0300, 16'h0200, 2'b00);
    check("b2b/hold_p", p_out, 16'h0055);
    check("b2b/hold_oor", oor_out, 4'b1000);
    check("b2b/valid", valid_out, 1'b0);
    check("b2b/ready", ready_out, 1'b0);
    wait_valid(lat);
    check("b2b2/lat", lat, LAT);
    check("b2b2/p", p_out, 16'h0180);
    @(posedge clk_in); #1;

    // Reset at cycle 10 with start_in also high: abort, reset wins.
    accept_op(16'h0100, 16'h0300, 2'b10);
    repeat (9) @(posedge clk_in);
    #1;
    rst_in = 1'b1; start_in = 1'b1;
    @(posedge clk_in); #1;
    check("mrst/p", p_out, 16'h0000);
    check("mrst/oor", oor_out, 4'b0000);
    check("mrst/valid", valid_out, 1'b0);
    check("mrst/ready", ready_out, 1'b1);
    rst_in = 1'b0; start_in = 1'b0;
    count_valid(40, hits);
    check("mrst/no_valid", hits, 0);

    run_op("post_rst", 16'h0100, 16'h0300, 2'b10, 16'h0056, 4'b1000, LAT);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
